// File: rtl/motor_pwm_ramp_ctrl.sv
// N-channel H-bridge PWM driver with linear duty ramping, dead-timed direction
// reversal, brake and a global emergency stop.
module motor_pwm_ramp_ctrl #(
  parameter int NUM_CH   = 2,
  parameter int PWM_W    = 8,
  parameter int RAMP_DIV = 64,
  parameter int DEAD_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*NUM_CH-1:0]     cmd_dir,
  input  logic [PWM_W*NUM_CH-1:0] cmd_duty,
  input  logic                    estop,
  output logic [NUM_CH-1:0]       out_a,
  output logic [NUM_CH-1:0]       out_b,
  output logic [NUM_CH-1:0]       settled
);

  localparam int RC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DC_W = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;

  localparam logic [1:0] CMD_FWD   = 2'b01;
  localparam logic [1:0] CMD_REV   = 2'b10;
  localparam logic [1:0] CMD_BRAKE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_DOWN,
    ST_DEAD,
    ST_BRAKE
  } state_t;

  logic [PWM_W-1:0] pwm_cnt;
  logic [RC_W-1:0]  ramp_cnt;
  logic             ramp_tick;

  assign ramp_tick = (ramp_cnt == RC_W'(RAMP_DIV - 1));

  function automatic logic [PWM_W-1:0] step_toward(input logic [PWM_W-1:0] cur,
                                                   input logic [PWM_W-1:0] goal);
    if (cur < goal)      return cur + 1'b1;
    else if (cur > goal) return cur - 1'b1;
    else                 return cur;
  endfunction

  // One shared PWM carrier and ramp-rate divider keep all channels phase aligned.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_cnt  <= '0;
      ramp_cnt <= '0;
    end else begin
      pwm_cnt  <= pwm_cnt + 1'b1;
      ramp_cnt <= ramp_tick ? '0 : ramp_cnt + 1'b1;
    end
  end

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    state_t           state, state_nxt;
    logic [PWM_W-1:0] cur_duty, duty_nxt, target;
    logic             cur_dir, dir_nxt;
    logic [DC_W-1:0]  dead_cnt, dead_nxt;
    logic [1:0]       cmd;
    logic             cmd_drive, cmd_rev, pwm_on;
    logic             drive_a, drive_b, settle_now;
    logic             a_q, b_q, settled_q;

    assign cmd       = cmd_dir[2*ch +: 2];
    assign cmd_rev   = (cmd == CMD_REV);
    assign cmd_drive = (cmd == CMD_FWD) || cmd_rev;
    assign target    = cmd_drive ? cmd_duty[PWM_W*ch +: PWM_W] : '0;
    assign pwm_on    = (pwm_cnt < cur_duty);

    // cur_dir: 0 = forward (pin A), 1 = reverse (pin B)
    always_comb begin
      state_nxt = state;
      duty_nxt  = cur_duty;
      dir_nxt   = cur_dir;
      dead_nxt  = dead_cnt;
      drive_a   = 1'b0;
      drive_b   = 1'b0;
      case (state)
        ST_IDLE: begin
          duty_nxt = '0;
          if (cmd_drive) begin
            dir_nxt   = cmd_rev;
            state_nxt = ST_RUN;
          end else if (cmd == CMD_BRAKE) begin
            state_nxt = ST_BRAKE;
          end
        end
        ST_RUN: begin
          drive_a = pwm_on & ~cur_dir;
          drive_b = pwm_on & cur_dir;
          if (cmd == CMD_BRAKE) begin
            state_nxt = ST_BRAKE;
            duty_nxt  = '0;
          end else if (cmd_drive && (cmd_rev != cur_dir)) begin
            state_nxt = ST_DOWN;
          end else if (!cmd_drive && (cur_duty == '0)) begin
            state_nxt = ST_IDLE;
          end else if (ramp_tick) begin
            duty_nxt = step_toward(cur_duty, target);
          end
        end
        ST_DOWN: begin
          drive_a = pwm_on & ~cur_dir;
          drive_b = pwm_on & cur_dir;
          if (cmd == CMD_BRAKE) begin
            state_nxt = ST_BRAKE;
            duty_nxt  = '0;
          end else if (cmd_drive && (cmd_rev == cur_dir)) begin
            state_nxt = ST_RUN;
          end else if (cur_duty == '0) begin
            state_nxt = ST_DEAD;
            dead_nxt  = '0;
          end else if (ramp_tick) begin
            duty_nxt = step_toward(cur_duty, '0);
          end
        end
        ST_DEAD: begin
          duty_nxt = '0;
          if (dead_cnt == DC_W'(DEAD_CYC - 1)) begin
            dead_nxt = '0;
            if (cmd_drive) begin
              dir_nxt   = cmd_rev;
              state_nxt = ST_RUN;
            end else if (cmd == CMD_BRAKE) begin
              state_nxt = ST_BRAKE;
            end else begin
              state_nxt = ST_IDLE;
            end
          end else begin
            dead_nxt = dead_cnt + 1'b1;
          end
        end
        ST_BRAKE: begin
          drive_a  = 1'b1;
          drive_b  = 1'b1;
          duty_nxt = '0;
          if (cmd_drive) begin
            dir_nxt   = cmd_rev;
            state_nxt = ST_RUN;
          end else if (cmd != CMD_BRAKE) begin
            state_nxt = ST_IDLE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
      // Emergency stop overrides every other event and blanks the pins on the next edge.
      if (estop) begin
        state_nxt = ST_IDLE;
        duty_nxt  = '0;
        drive_a   = 1'b0;
        drive_b   = 1'b0;
      end
    end

    assign settle_now = ((state == ST_RUN) || (state == ST_IDLE) || (state == ST_BRAKE))
                        && (cur_duty == target);

    always_ff @(posedge clk) begin
      if (rst) begin
        state     <= ST_IDLE;
        cur_duty  <= '0;
        cur_dir   <= 1'b0;
        dead_cnt  <= '0;
        a_q       <= 1'b0;
        b_q       <= 1'b0;
        settled_q <= 1'b1;
      end else begin
        state     <= state_nxt;
        cur_duty  <= duty_nxt;
        cur_dir   <= dir_nxt;
        dead_cnt  <= dead_nxt;
        a_q       <= drive_a;
        b_q       <= drive_b;
        settled_q <= settle_now;
      end
    end

    assign out_a[ch]   = a_q;
    assign out_b[ch]   = b_q;
    assign settled[ch] = settled_q;
  end

endmodule

// File: tb/tb_motor_pwm_ramp_ctrl.sv
// Directed self-checking bench for motor_pwm_ramp_ctrl (3 channels, fast ramp).
module tb_motor_pwm_ramp_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] cmd_dir;
  logic [23:0] cmd_duty;
  logic       estop;
  logic [2:0] out_a, out_b, settled;

  logic [7:0] ref_cnt;
  int checks = 0;
  int errors = 0;

  motor_pwm_ramp_ctrl #(
    .NUM_CH(3), .PWM_W(8), .RAMP_DIV(4), .DEAD_CYC(16)
  ) dut (
    .clk(clk), .rst(rst), .cmd_dir(cmd_dir), .cmd_duty(cmd_duty), .estop(estop),
    .out_a(out_a), .out_b(out_b), .settled(settled)
  );

  always #5 clk = ~clk;

  // Independent copy of the PWM carrier phase, restarted by reset like the DUT's.
  always @(posedge clk) ref_cnt <= rst ? 8'd0 : ref_cnt + 8'd1;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input int ch, input logic [1:0] dir, input logic [7:0] duty);
    cmd_dir[2*ch +: 2]  = dir;
    cmd_duty[8*ch +: 8] = duty;
  endtask

  task automatic wait_settled(input int ch, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (settled[ch]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ref(input int value, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ref_cnt == 8'(value)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic count_high(input int ch, input int n, output int ca, output int cb);
    ca = 0;
    cb = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ca += int'(out_a[ch]);
      cb += int'(out_b[ch]);
    end
  endtask

  task automatic measure_first_pulse(input int ch, input bit use_b,
                                     output int first_cnt, output int width);
    logic pin;
    pin = 1'b0;
    first_cnt = -1;
    width = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      pin = use_b ? out_b[ch] : out_a[ch];
      if (pin) begin
        first_cnt = int'(ref_cnt);
        break;
      end
    end
    while (pin && width < 300) begin
      width++;
      @(negedge clk);
      pin = use_b ? out_b[ch] : out_a[ch];
    end
  endtask

  initial begin
    bit ok;
    int ca, cb, last_a, first_b, overlap, gap, saw_a, i, fc, w;

    rst = 1'b1;
    estop = 1'b0;
    cmd_dir = '0;
    cmd_duty = '0;
    repeat (3) @(negedge clk);
    check("reset_out_a", int'(out_a), 0);
    check("reset_out_b", int'(out_b), 0);
    check("reset_settled", int'(settled), 7);
    rst = 1'b0;

    // Soft start of ch0 forward to half duty: 128 ramp steps of 4 cycles.
    apply_stimulus(0, 2'b01, 8'd128);
    repeat (400) @(negedge clk);
    check("t1_ramping_not_settled", int'(settled[0]), 0);
    wait_settled(0, 300, ok);
    check("t1_settled", int'(ok), 1);
    count_high(0, 256, ca, cb);
    check("t1_a_high_cnt", ca, 128);
    check("t1_b_high_cnt", cb, 0);

    apply_stimulus(0, 2'b01, 8'd100);
    wait_settled(0, 300, ok);
    check("t2_fwd100_settled", int'(ok), 1);
    count_high(0, 256, ca, cb);
    check("t2_fwd100_a_cnt", ca, 100);

    // Reversal: A pulses shrink away, coast gap, then B pulses grow.
    apply_stimulus(0, 2'b10, 8'd100);
    last_a = -1;
    first_b = -1;
    overlap = 0;
    for (i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (out_a[0]) last_a = i;
      if (out_b[0] && first_b < 0) first_b = i;
      if (out_a[0] && out_b[0]) overlap++;
      if (first_b >= 0 && settled[0]) break;
    end
    check("t2_reversal_done", int'(i < 1500), 1);
    gap = first_b - last_a - 1;
    check("t2_dead_gap_ge_16", int'(gap >= 16), 1);
    check("t2_no_overlap", overlap, 0);
    count_high(0, 256, ca, cb);
    check("t2_rev100_b_cnt", cb, 100);
    check("t2_rev100_a_cnt", ca, 0);

    // Aborted reversal: flip back during the ramp-down, must resume quickly without A.
    apply_stimulus(0, 2'b01, 8'd100);
    saw_a = 0;
    repeat (40) begin
      @(negedge clk);
      saw_a += int'(out_a[0]);
    end
    apply_stimulus(0, 2'b10, 8'd100);
    ok = 1'b0;
    for (int k = 0; k < 120; k++) begin
      @(negedge clk);
      saw_a += int'(out_a[0]);
      if (settled[0]) begin
        ok = 1'b1;
        break;
      end
    end
    check("t5_back_to_run_fast", int'(ok), 1);
    check("t5_no_a_pulse", saw_a, 0);
    count_high(0, 256, ca, cb);
    check("t5_rev100_b_cnt", cb, 100);

    // Emergency stop on ch1 running reverse 200, timed so the restart ramp lines up with the carrier wrap.
    apply_stimulus(1, 2'b10, 8'd200);
    wait_settled(1, 1000, ok);
    check("t3_rev200_settled", int'(ok), 1);
    wait_ref(250, ok);
    check("t3_align", int'(ok), 1);
    estop = 1'b1;
    @(negedge clk);
    check("t3_estop_out_a", int'(out_a), 0);
    check("t3_estop_out_b", int'(out_b), 0);
    estop = 1'b0;
    measure_first_pulse(1, 1'b1, fc, w);
    check("t3_first_b_phase", fc, 1);
    check("t3_first_b_width", w, 1);

    // Brake from full duty, then restart from zero.
    apply_stimulus(0, 2'b01, 8'd255);
    wait_settled(0, 3000, ok);
    check("t4_fwd255_settled", int'(ok), 1);
    count_high(0, 256, ca, cb);
    check("t4_fwd255_a_cnt", ca, 255);
    apply_stimulus(0, 2'b11, 8'd255);
    repeat (2) @(negedge clk);
    check("t4_brake_pins", int'({out_a[0], out_b[0]}), 3);
    count_high(0, 100, ca, cb);
    check("t4_brake_constant", ca + cb, 200);
    check("t4_brake_settled", int'(settled[0]), 1);
    wait_ref(251, ok);
    check("t4_align", int'(ok), 1);
    apply_stimulus(0, 2'b01, 8'd255);
    repeat (2) @(negedge clk);
    check("t4_release_pins", int'({out_a[0], out_b[0]}), 0);
    measure_first_pulse(0, 1'b0, fc, w);
    check("t4_first_a_phase", fc, 1);
    check("t4_first_a_width", w, 1);

    // Reset while ch2 sits in the dead time and ch0 is braking.
    apply_stimulus(0, 2'b11, 8'd0);
    apply_stimulus(2, 2'b01, 8'd4);
    wait_settled(2, 100, ok);
    check("t6_ch2_settled", int'(ok), 1);
    apply_stimulus(2, 2'b10, 8'd4);
    repeat (24) @(negedge clk);
    check("t6_ch2_dead_pins", int'({out_a[2], out_b[2]}), 0);
    check("t6_ch0_brake_pins", int'({out_a[0], out_b[0]}), 3);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_out_a", int'(out_a), 0);
    check("t6_rst_out_b", int'(out_b), 0);
    check("t6_rst_settled", int'(settled), 7);
    cmd_dir = '0;
    cmd_duty = '0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("t6_idle_settled", int'(settled), 7);
    check("t6_idle_pins", int'({out_a, out_b}), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
